// File: rtl/ula_pixel_serializer.sv
// ula_pixel_serializer
//   Video output stage of the ULA. This block captures the bitmap and attribute
//   bytes fetched from display DRAM and serialises the bitmap, MSB first, at one
//   pixel per pix_ce. It works out ink or paper, BRIGHT and FLASH for each pixel.
//   Outside the active area it substitutes the border colour. Its output is a
//   registered 4-bit colour index with blanking, which feeds the video DAC encoder.
//
// Ports
//   clk          master pixel clock
//   rst          synchronous reset, active-high
//   pix_ce       pixel enable; one pixel advances per asserted cycle
//   bitmap_in/ld fetched bitmap byte and its holding-register strobe
//   attr_in/ld   fetched attribute byte [7]=FLASH [6]=BRIGHT [5:3]=paper [2:0]=ink
//   shift_load   character boundary; qualified by pix_ce
//   display_en   active-area flag, sampled at shift_load
//   border_in/wr border colour GRB and its write strobe
//   vsync_pulse  frame strobe that advances the flash counter
//   blank_in     blanking, sampled on pix_ce
//   colour_out   {BRIGHT,G,R,B}, registered
//   blank_out    blanking aligned with colour_out
//   flash_state  current flash phase
module ula_pixel_serializer #(
    parameter int FLASH_FRAMES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    input  logic [7:0] bitmap_in,
    input  logic       bitmap_ld,
    input  logic [7:0] attr_in,
    input  logic       attr_ld,
    input  logic       shift_load,
    input  logic       display_en,
    input  logic [2:0] border_in,
    input  logic       border_wr,
    input  logic       vsync_pulse,
    input  logic       blank_in,
    output logic [3:0] colour_out,
    output logic       blank_out,
    output logic       flash_state
);

    localparam logic [4:0] FLASH_LAST = 5'(FLASH_FRAMES - 1);

    logic [7:0] bitmap_hold;
    logic [7:0] attr_hold;
    logic [2:0] border_reg;
    logic [7:0] shift_reg;
    logic [7:0] attr_reg;
    logic       mode;
    logic [2:0] border_shadow;
    logic [4:0] flash_cnt;

    logic       ink_sel;
    logic [3:0] colour_nxt;

    // Fetch-side holding registers are written on any edge, whatever pix_ce is.
    // If a write lands on the same edge as a load, the load still sees the old
    // value, because non-blocking assignment reads the pre-edge contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap_hold <= '0;
            attr_hold   <= '0;
            border_reg  <= '0;
        end else begin
            if (bitmap_ld) bitmap_hold <= bitmap_in;
            if (attr_ld)   attr_hold   <= attr_in;
            if (border_wr) border_reg  <= border_in;
        end
    end

    // Frame counter. It wraps at FLASH_FRAMES-1 and flips the flash phase on
    // that same edge. A held vsync_pulse counts once per clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            flash_cnt   <= '0;
            flash_state <= 1'b0;
        end else if (vsync_pulse) begin
            if (flash_cnt == FLASH_LAST) begin
                flash_cnt   <= '0;
                flash_state <= ~flash_state;
            end else begin
                flash_cnt <= flash_cnt + 5'd1;
            end
        end
    end

    // Shifter and per-character state
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg     <= '0;
            attr_reg      <= '0;
            mode          <= 1'b0;
            border_shadow <= '0;
        end else if (pix_ce) begin
            if (shift_load) begin
                shift_reg     <= display_en ? bitmap_hold : 8'h00;
                attr_reg      <= attr_hold;
                mode          <= display_en;
                border_shadow <= border_reg;
            end else begin
                // Zeros shifted in past the end of a character read as paper.
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

    // Colour of the pixel currently at the shifter MSB. FLASH swaps ink and
    // paper during the active flash phase.
    always_comb begin
        ink_sel    = shift_reg[7] ^ (attr_reg[7] & flash_state);
        colour_nxt = '0;
        if (blank_in)
            colour_nxt = '0;
        else if (mode)
            colour_nxt = {attr_reg[6], ink_sel ? attr_reg[2:0] : attr_reg[5:3]};
        else
            colour_nxt = {1'b0, border_shadow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            colour_out <= '0;
            blank_out  <= 1'b0;
        end else if (pix_ce) begin
            colour_out <= colour_nxt;
            blank_out  <= blank_in;
        end
    end

endmodule

// File: tb/tb_ula_pixel_serializer.sv
// Directed bench for ula_pixel_serializer. Inputs change 1 ns after each rising
// edge, and outputs are sampled at that same point.
module tb_ula_pixel_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_ce;
    logic [7:0] bitmap_in;
    logic       bitmap_ld;
    logic [7:0] attr_in;
    logic       attr_ld;
    logic       shift_load;
    logic       display_en;
    logic [2:0] border_in;
    logic       border_wr;
    logic       vsync_pulse;
    logic       blank_in;
    logic [3:0] colour_out;
    logic       blank_out;
    logic       flash_state;

    int checks = 0;
    int errors = 0;

    ula_pixel_serializer #(.FLASH_FRAMES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_ce     (pix_ce),
        .bitmap_in  (bitmap_in),
        .bitmap_ld  (bitmap_ld),
        .attr_in    (attr_in),
        .attr_ld    (attr_ld),
        .shift_load (shift_load),
        .display_en (display_en),
        .border_in  (border_in),
        .border_wr  (border_wr),
        .vsync_pulse(vsync_pulse),
        .blank_in   (blank_in),
        .colour_out (colour_out),
        .blank_out  (blank_out),
        .flash_state(flash_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Put a byte pair into the holding registers without touching the shifter.
    task automatic hold(input logic [7:0] bm, input logic [7:0] at);
        bitmap_in = bm; bitmap_ld = 1'b1;
        attr_in   = at; attr_ld   = 1'b1;
        tick();
        bitmap_ld = 1'b0; attr_ld = 1'b0;
    endtask

    logic [3:0] exp_a5 [8];

    initial begin
        exp_a5 = '{4'hF, 4'h8, 4'hF, 4'h8, 4'h8, 4'hF, 4'h8, 4'hF};

        rst = 1'b0; pix_ce = 1'b0; bitmap_in = '0; bitmap_ld = 1'b0;
        attr_in = '0; attr_ld = 1'b0; shift_load = 1'b0; display_en = 1'b0;
        border_in = '0; border_wr = 1'b0; vsync_pulse = 1'b0; blank_in = 1'b0;

        // Reset while everything else toggles
        rst = 1'b1; pix_ce = 1'b1; bitmap_in = 8'hFF; bitmap_ld = 1'b1;
        attr_in = 8'hFF; attr_ld = 1'b1; shift_load = 1'b1; display_en = 1'b1;
        border_in = 3'b111; border_wr = 1'b1; vsync_pulse = 1'b1; blank_in = 1'b1;
        tick();
        shift_load = 1'b0; blank_in = 1'b0;
        tick();
        chk("rst_colour", colour_out, 4'h0);
        chk("rst_blank", {3'b0, blank_out}, 4'h0);
        chk("rst_flash", {3'b0, flash_state}, 4'h0);

        rst = 1'b0; bitmap_ld = 1'b0; attr_ld = 1'b0; border_wr = 1'b0;
        vsync_pulse = 1'b0; display_en = 1'b0; shift_load = 1'b1;
        tick();
        shift_load = 1'b0;
        tick();
        chk("post_rst_border", colour_out, 4'h0);

        // Serialise 0xA5 with attr 0x47, then reload on the 8th ce with no gap
        hold(8'hA5, 8'h47);
        display_en = 1'b1; shift_load = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            shift_load = (i == 7);
            tick();
            chk($sformatf("ser_px%0d", 7 - i), colour_out, exp_a5[i]);
        end
        shift_load = 1'b0;
        tick();
        chk("ser_gapless_px7", colour_out, 4'hF);
        tick();
        chk("ser_gapless_px6", colour_out, 4'h8);

        // A border write on a load edge is seen only at the next load
        display_en = 1'b0; border_in = 3'b010; border_wr = 1'b1; shift_load = 1'b1;
        tick();
        border_wr = 1'b0; shift_load = 1'b0;
        tick();
        chk("border_old", colour_out, 4'h0);
        shift_load = 1'b1;
        tick();
        shift_load = 1'b0;
        tick();
        chk("border_new", colour_out, 4'h2);

        // The same collision rule applies to bitmap_ld (hold is still 0xA5)
        display_en = 1'b1; bitmap_in = 8'h3C; bitmap_ld = 1'b1; shift_load = 1'b1;
        tick();
        bitmap_ld = 1'b0; shift_load = 1'b0;
        tick();
        chk("bm_old_px7", colour_out, 4'hF);
        tick();
        chk("bm_old_px6", colour_out, 4'h8);
        shift_load = 1'b1;
        tick();
        shift_load = 1'b0;
        tick();
        chk("bm_new_px7", colour_out, 4'h8);
        tick();
        chk("bm_new_px6", colour_out, 4'h8);
        tick();
        chk("bm_new_px5", colour_out, 4'hF);

        // Flash, with attr 0x87 and bitmap 0xF0
        hold(8'hF0, 8'h87);
        shift_load = 1'b1;
        tick();
        shift_load = 1'b0;
        tick();
        chk("flash0_px7", colour_out, 4'h7);
        repeat (3) tick();
        tick();
        chk("flash0_px3", colour_out, 4'h0);
        pix_ce = 1'b0;
        vsync_pulse = 1'b1;
        repeat (15) tick();
        vsync_pulse = 1'b0;
        tick();
        chk("flash_after15", {3'b0, flash_state}, 4'h0);
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        chk("flash_after16", {3'b0, flash_state}, 4'h1);
        chk("flash_ce_hold", colour_out, 4'h0);
        pix_ce = 1'b1; shift_load = 1'b1;
        tick();
        shift_load = 1'b0;
        tick();
        chk("flash1_px7", colour_out, 4'h0);
        repeat (3) tick();
        tick();
        chk("flash1_px3", colour_out, 4'h7);
        vsync_pulse = 1'b1;
        repeat (15) tick();
        chk("flash_after31", {3'b0, flash_state}, 4'h1);
        tick();
        vsync_pulse = 1'b0;
        chk("flash_after32", {3'b0, flash_state}, 4'h0);

        // pix_ce on every other clk, with a blanked slot in the middle
        hold(8'hA5, 8'h47);
        pix_ce = 1'b1; shift_load = 1'b1;
        tick();
        shift_load = 1'b0; pix_ce = 1'b0;
        tick();
        pix_ce = 1'b1;
        tick();
        chk("ce_px7", colour_out, 4'hF);
        pix_ce = 1'b0;
        tick();
        chk("ce_px7_hold", colour_out, 4'hF);
        pix_ce = 1'b1; blank_in = 1'b1;
        tick();
        chk("blank_colour", colour_out, 4'h0);
        chk("blank_out_hi", {3'b0, blank_out}, 4'h1);
        pix_ce = 1'b0; blank_in = 1'b0;
        tick();
        chk("blank_hold", {3'b0, blank_out}, 4'h1);
        pix_ce = 1'b1;
        tick();
        chk("blank_shift_px5", colour_out, 4'hF);
        chk("blank_out_lo", {3'b0, blank_out}, 4'h0);

        // Reset in the middle of a character
        hold(8'hFF, 8'h47);
        shift_load = 1'b1;
        tick();
        shift_load = 1'b0;
        repeat (3) tick();
        chk("mid_px5", colour_out, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_colour", colour_out, 4'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mid_rst_tail%0d", i), colour_out, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
